// File: rtl/ex_lfsr8_checker.sv
// ex_lfsr8_checker: checks a burst of read bytes against an 8-bit LFSR pattern.
// Counts mismatching beats (saturating) and captures the first mismatch.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; results of the last test retained
// S_RUN  | checking beats; one compare per rdata_valid cycle
// S_DONE | BURST_LEN beats checked; results and pass held
module ex_lfsr8_checker #(
  parameter int unsigned SEED      = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [7:0]       i_rdata,
  input  logic             i_rdata_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [15:0]      o_first_err_idx,
  output logic [7:0]       o_first_err_data,
  output logic [7:0]       o_first_err_exp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]  SEED_B   = 8'(SEED);
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  state_t           r_state;
  logic [7:0]       r_exp;
  logic [15:0]      r_beat;
  logic [ERR_W-1:0] r_err_count;
  logic [15:0]      r_first_err_idx;
  logic [7:0]       r_first_err_data;
  logic [7:0]       r_first_err_exp;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [7:0]       w_exp_next;
  logic             w_mismatch;
  logic             w_first_err;
  logic             w_last_beat;
  logic [ERR_W-1:0] w_err_next;

  // Next pattern byte, expected compare result and saturating error count
  always_comb begin
    w_exp_next  = {r_exp[6:4],
                   r_exp[3] ^ r_exp[7],
                   r_exp[2] ^ r_exp[7],
                   r_exp[1] ^ r_exp[7],
                   r_exp[0],
                   r_exp[7]};
    w_mismatch  = (i_rdata != r_exp);
    // err_count only ever grows within a test, so zero means no mismatch yet
    w_first_err = w_mismatch && (r_err_count == '0);
    w_last_beat = (r_beat == LAST_IDX);
    w_err_next  = r_err_count;
    if (w_mismatch && !(&r_err_count)) begin
      w_err_next = r_err_count + ERR_W'(1);
    end
  end

  // Sequencer, pattern/beat tracking and result capture; abort has priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_exp            <= SEED_B;
      r_beat           <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_first_err_exp  <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state          <= S_RUN;
            r_exp            <= SEED_B;
            r_beat           <= '0;
            r_err_count      <= '0;
            r_first_err_idx  <= '0;
            r_first_err_data <= '0;
            r_first_err_exp  <= '0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_rdata_valid) begin
            r_exp       <= w_exp_next;
            r_beat      <= r_beat + 16'd1;
            r_err_count <= w_err_next;
            if (w_first_err) begin
              r_first_err_idx  <= r_beat;
              r_first_err_data <= i_rdata;
              r_first_err_exp  <= r_exp;
            end
            if (w_last_beat) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_err_idx  = r_first_err_idx;
  assign o_first_err_data = r_first_err_data;
  assign o_first_err_exp  = r_first_err_exp;

endmodule
